mpte_fetch_stage: RTL and testbench

MPTE_FETCH_STAGE -- requirements
Module: mpte_fetch_stage

---
 rtl/mpt_pkg.sv | 32 +++
 rtl/mpte_fetch_stage.sv | 141 ++++++++++++++
 tb/tb_mpte_fetch_stage.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpt_pkg.sv
// Shared MPT walker types: walk transaction bundle and fetch FSM states.
// XLEN and the default fetch timeout live here for all walk stages.
package mpt_pkg;

  localparam int XLEN = 64;
  localparam int MPT_FETCH_TIMEOUT = 64;

  typedef enum logic [1:0] {
    MPT_WALKING_ACTIVE = 2'd0,
    MPT_WALKING_SKIP   = 2'd1,
    MPT_WALKING_DONE   = 2'd2,
    MPT_WALKING_RSVD   = 2'd3
  } mpt_walking_e;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_HOLD = 2'd3
  } mpte_fetch_state_e;

  typedef struct packed {
    logic [7:0]      id;
    logic            valid;
    logic            completed;
    logic            access_error;
    mpt_walking_e    walking;
    logic [XLEN-1:0] mpte_ptr;
    logic [XLEN-1:0] mpte;
  } mptw_transaction_t;

endpackage

// File: rtl/mpte_fetch_stage.sv
// MPT walk stage: fetches one MPTE over a read-only memory port.
// Define MPTE_FETCH_TIMEOUT_EN to turn a missing response into an error.
module mpte_fetch_stage
  import mpt_pkg::*;
#(
  parameter int PIPELINE_SLAVE_DATA_WIDTH  = 32,
  parameter int PIPELINE_MASTER_DATA_WIDTH = 32,
  parameter int WALKING_LEVEL              = 0,
  parameter int TIMEOUT_CYCLES             = MPT_FETCH_TIMEOUT
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  stage_slave_data,
  input  logic                                  stage_slave_valid,
  output logic                                  stage_slave_ready,
  output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] stage_master_data,
  output logic                                  stage_master_valid,
  input  logic                                  stage_master_ready,
  output logic                                  mem_req_o,
  output logic [XLEN-1:0]                       mem_addr_o,
  input  logic                                  mem_gnt_i,
  input  logic                                  mem_rvalid_i,
  input  logic [XLEN-1:0]                       mem_rdata_i,
  input  logic                                  mem_err_i,
  output logic                                  bus_error_o
);

  localparam int TW = $bits(mptw_transaction_t);
  localparam int SW = PIPELINE_SLAVE_DATA_WIDTH;
  localparam int MW = PIPELINE_MASTER_DATA_WIDTH;

  mptw_transaction_t in_txn;
  mptw_transaction_t txn_q;
  mptw_transaction_t txn_d;
  mpte_fetch_state_e state_q;
  mpte_fetch_state_e state_d;
  logic              rsp_ok;
  logic              rsp_err;
  logic              timeout;
  logic              unused_cfg;

  // Bus widths are free parameters; truncate or zero-extend at the edges.
  if (SW > TW) begin : g_in_wide
    logic unused_in;
    assign in_txn = stage_slave_data[TW-1:0];
    assign unused_in = ^stage_slave_data[SW-1:TW];
  end else if (SW == TW) begin : g_in_eq
    assign in_txn = stage_slave_data;
  end else begin : g_in_narrow
    assign in_txn = {{(TW-SW){1'b0}}, stage_slave_data};
  end

  if (MW > TW) begin : g_out_wide
    assign stage_master_data = {{(MW-TW){1'b0}}, txn_q};
  end else if (MW == TW) begin : g_out_eq
    assign stage_master_data = txn_q;
  end else begin : g_out_narrow
    logic unused_out;
    assign stage_master_data = txn_q[MW-1:0];
    assign unused_out = ^txn_q[TW-1:MW];
  end

`ifdef MPTE_FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else if (state_q != FETCH_WAIT) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign timeout = (state_q == FETCH_WAIT)
                && (tmo_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign unused_cfg = WALKING_LEVEL[0] ^ TIMEOUT_CYCLES[0];

  assign rsp_ok  = (state_q == FETCH_WAIT)
                && mem_rvalid_i && !mem_err_i;
  assign rsp_err = (state_q == FETCH_WAIT)
                && ((mem_rvalid_i && mem_err_i)
                 || (timeout && !mem_rvalid_i));

  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    unique case (state_q)
      FETCH_IDLE: begin
        if (stage_slave_valid) begin
          txn_d = in_txn;
          if (!in_txn.valid || in_txn.walking == MPT_WALKING_SKIP) begin
            state_d = FETCH_HOLD;
          end else begin
            state_d = FETCH_REQ;
          end
        end
      end
      FETCH_REQ: begin
        if (mem_gnt_i) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (rsp_ok) begin
          txn_d.mpte = mem_rdata_i;
          state_d    = FETCH_HOLD;
        end else if (rsp_err) begin
          txn_d.access_error = 1'b1;
          txn_d.completed    = 1'b1;
          txn_d.walking      = MPT_WALKING_SKIP;
          state_d            = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        if (stage_master_ready) state_d = FETCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FETCH_IDLE;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
    end
  end

  assign stage_slave_ready  = (state_q == FETCH_IDLE);
  assign stage_master_valid = (state_q == FETCH_HOLD);
  assign mem_req_o          = (state_q == FETCH_REQ);
  assign mem_addr_o         = txn_q.mpte_ptr;
  assign bus_error_o        = rsp_err;

endmodule

// File: tb/tb_mpte_fetch_stage.sv
// Directed bench for mpte_fetch_stage; build with MPTE_FETCH_TIMEOUT_EN
// to also exercise the response timeout (TIMEOUT_CYCLES = 8).
module tb_mpte_fetch_stage;
  import mpt_pkg::*;

  localparam int TW = $bits(mptw_transaction_t);

  logic            clk;
  logic            rst_n;
  logic [TW-1:0]   s_data;
  logic            s_valid;
  logic            s_ready;
  logic [TW-1:0]   m_data;
  logic            m_valid;
  logic            m_ready;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_err;
  logic            bus_err;

  int total = 0;
  int bad   = 0;
  int req_cycles = 0;

  mpte_fetch_stage #(
    .PIPELINE_SLAVE_DATA_WIDTH (TW),
    .PIPELINE_MASTER_DATA_WIDTH(TW),
    .WALKING_LEVEL             (0),
    .TIMEOUT_CYCLES            (8)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .stage_slave_data  (s_data),
    .stage_slave_valid (s_valid),
    .stage_slave_ready (s_ready),
    .stage_master_data (m_data),
    .stage_master_valid(m_valid),
    .stage_master_ready(m_ready),
    .mem_req_o         (mem_req),
    .mem_addr_o        (mem_addr),
    .mem_gnt_i         (mem_gnt),
    .mem_rvalid_i      (mem_rvalid),
    .mem_rdata_i       (mem_rdata),
    .mem_err_i         (mem_err),
    .bus_error_o       (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mem_req === 1'b1) req_cycles++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input mptw_transaction_t t);
    s_data  = t;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  function automatic mptw_transaction_t mk(
    input logic [7:0] id, input mpt_walking_e w,
    input logic [XLEN-1:0] ptr, input logic [XLEN-1:0] mpte);
    mptw_transaction_t t;
    t = '0;
    t.id = id;
    t.valid = 1'b1;
    t.walking = w;
    t.mpte_ptr = ptr;
    t.mpte = mpte;
    return t;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({s_ready, m_valid, mem_req, bus_err} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_ctrl got %b want 1000",
               {s_ready, m_valid, mem_req, bus_err});
    end
    total++;
    if (m_data !== '0) begin
      bad++;
      $display("FAIL reset_data got %h want 0", m_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_normal;
    mptw_transaction_t t, e;
    int r0;
    t = mk(8'h11, MPT_WALKING_ACTIVE, 64'h8000_1008, 64'h0);
    e = t;
    e.mpte = 64'h0000_0000_2000_0001;
    r0 = req_cycles;
    mem_gnt = 1'b1;
    send(t);
    @(negedge clk);
    total++;
    if ({m_valid, mem_req, mem_addr} !== {2'b01, t.mpte_ptr}) begin
      bad++;
      $display("FAIL norm_req got v=%b r=%b a=%h want 0 1 %h",
               m_valid, mem_req, mem_addr, t.mpte_ptr);
    end
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 64'h0000_0000_2000_0001;
    @(negedge clk);
    total++;
    if ({m_valid, mem_req, bus_err} !== 3'b000) begin
      bad++;
      $display("FAIL norm_wait got %b want 000",
               {m_valid, mem_req, bus_err});
    end
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    total++;
    if (m_valid !== 1'b1 || m_data !== e) begin
      bad++;
      $display("FAIL norm_out got v=%b %h want 1 %h", m_valid, m_data, e);
    end
    total++;
    if (req_cycles - r0 !== 1) begin
      bad++;
      $display("FAIL norm_reqcnt got %0d want 1", req_cycles - r0);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({m_valid, s_ready} !== 2'b01) begin
      bad++;
      $display("FAIL norm_done got %b want 01", {m_valid, s_ready});
    end
    tick();
  endtask

  task automatic test_skip;
    mptw_transaction_t t;
    int r0;
    r0 = req_cycles;
    t = mk(8'h22, MPT_WALKING_SKIP, 64'h1234_5678, 64'hABCD);
    send(t);
    @(negedge clk);
    total++;
    if ({m_valid, mem_req} !== 2'b10 || m_data !== t) begin
      bad++;
      $display("FAIL skip_out got v=%b r=%b %h want 1 0 %h",
               m_valid, mem_req, m_data, t);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    t = mk(8'h23, MPT_WALKING_ACTIVE, 64'h4444_0000, 64'h99);
    t.valid = 1'b0;
    send(t);
    @(negedge clk);
    total++;
    if ({m_valid, mem_req} !== 2'b10 || m_data !== t) begin
      bad++;
      $display("FAIL skip_inv got v=%b r=%b %h want 1 0 %h",
               m_valid, mem_req, m_data, t);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    total++;
    if (req_cycles != r0) begin
      bad++;
      $display("FAIL skip_reqcnt got %0d want 0", req_cycles - r0);
    end
  endtask

  task automatic test_grant_stall;
    mptw_transaction_t t, e;
    int r0;
    t = mk(8'h33, MPT_WALKING_ACTIVE, 64'h8000_2010, 64'h0);
    e = t;
    e.mpte = 64'h3000_0003;
    r0 = req_cycles;
    mem_gnt = 1'b0;
    send(t);
    for (int i = 0; i < 6; i++) begin
      mem_rvalid = (i == 0);
      mem_err = (i == 0);
      mem_rdata = 64'hBAD;
      if (i == 5) mem_gnt = 1'b1;
      @(negedge clk);
      total++;
      if ({mem_req, mem_addr, bus_err} !== {1'b1, t.mpte_ptr, 1'b0}) begin
        bad++;
        $display("FAIL stall_%0d got r=%b a=%h e=%b want 1 %h 0",
                 i, mem_req, mem_addr, bus_err, t.mpte_ptr);
      end
      tick();
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_err = 1'b0;
    mem_rdata = 64'h3000_0003;
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    total++;
    if (m_valid !== 1'b1 || m_data !== e) begin
      bad++;
      $display("FAIL stall_out got v=%b %h want 1 %h", m_valid, m_data, e);
    end
    total++;
    if (req_cycles - r0 !== 6) begin
      bad++;
      $display("FAIL stall_reqcnt got %0d want 6", req_cycles - r0);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_error;
    mptw_transaction_t t, e;
    t = mk(8'h44, MPT_WALKING_ACTIVE, 64'h8000_3000, 64'hDEAD_BEEF);
    e = t;
    e.access_error = 1'b1;
    e.completed = 1'b1;
    e.walking = MPT_WALKING_SKIP;
    mem_gnt = 1'b1;
    send(t);
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_err = 1'b1;
    mem_rdata = 64'h5A5A;
    @(negedge clk);
    total++;
    if (bus_err !== 1'b1) begin
      bad++;
      $display("FAIL err_pulse got %b want 1", bus_err);
    end
    tick();
    mem_rvalid = 1'b0;
    mem_err = 1'b0;
    @(negedge clk);
    total++;
    if ({m_valid, bus_err} !== 2'b10 || m_data !== e) begin
      bad++;
      $display("FAIL err_out got v=%b e=%b %h want 1 0 %h",
               m_valid, bus_err, m_data, e);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    mptw_transaction_t t, e, u;
    t = mk(8'h55, MPT_WALKING_ACTIVE, 64'h8000_4000, 64'h0);
    e = t;
    e.mpte = 64'h5555;
    u = mk(8'h56, MPT_WALKING_SKIP, 64'h77, 64'h66);
    mem_gnt = 1'b1;
    send(t);
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 64'h5555;
    tick();
    mem_rvalid = 1'b0;
    s_data = u;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({m_valid, s_ready} !== 2'b10 || m_data !== e) begin
        bad++;
        $display("FAIL bp_%0d got v=%b s=%b %h want 1 0 %h",
                 i, m_valid, s_ready, m_data, e);
      end
      tick();
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({m_valid, s_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_nob2b got %b want 01", {m_valid, s_ready});
    end
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    total++;
    if (m_valid !== 1'b1 || m_data !== u) begin
      bad++;
      $display("FAIL bp_next got v=%b %h want 1 %h", m_valid, m_data, u);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    mptw_transaction_t t;
    t = mk(8'h66, MPT_WALKING_ACTIVE, 64'h8000_5000, 64'h0);
    mem_gnt = 1'b1;
    send(t);
    tick();
    mem_gnt = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({s_ready, m_valid, mem_req} !== 3'b100) begin
      bad++;
      $display("FAIL rstmid got %b want 100", {s_ready, m_valid, mem_req});
    end
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 64'h7777;
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    total++;
    if ({s_ready, m_valid, bus_err} !== 3'b100 || m_data !== '0) begin
      bad++;
      $display("FAIL rst_stray got %b %h want 100 0",
               {s_ready, m_valid, bus_err}, m_data);
    end
    tick();
  endtask

`ifdef MPTE_FETCH_TIMEOUT_EN
  task automatic test_timeout;
    mptw_transaction_t t, e;
    t = mk(8'h77, MPT_WALKING_ACTIVE, 64'h8000_6000, 64'h1);
    e = t;
    e.access_error = 1'b1;
    e.completed = 1'b1;
    e.walking = MPT_WALKING_SKIP;
    mem_gnt = 1'b1;
    send(t);
    tick();
    mem_gnt = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      total++;
      if (bus_err !== (k == 8)) begin
        bad++;
        $display("FAIL tmo_%0d got %b want %b", k, bus_err, k == 8);
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (m_valid !== 1'b1 || m_data !== e) begin
      bad++;
      $display("FAIL tmo_out got v=%b %h want 1 %h", m_valid, m_data, e);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    s_data = '0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    mem_err = 1'b0;
    test_reset();
    test_normal();
    test_skip();
    test_grant_stall();
    test_error();
    test_backpressure();
    test_reset_mid();
`ifdef MPTE_FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
